// File: rtl/dcache_top.sv
// Core + direct-mapped write-through data cache + unified on-chip memory.
// Define DCACHE_EN to build the cache; undefined, every LSU access bypasses to memory.

// Stand-in for the RI5CY core: debug-bus writes drive the LSU port directly.
module riscv_core #(
   parameter int          INSTR_RDATA_WIDTH = 128,
   parameter logic [31:0] BOOT_ADDR         = 32'h0
) (
   input  logic                         clk_i,
   input  logic                         rstn_i,
   input  logic                         irq_i,
   input  logic                         fetch_enable_i,
   output logic                         core_busy_o,
   output logic                         instr_req_o,
   output logic [31:0]                  instr_addr_o,
   input  logic                         instr_gnt_i,
   input  logic                         instr_rvalid_i,
   input  logic [INSTR_RDATA_WIDTH-1:0] instr_rdata_i,
   output logic                         data_req_o,
   output logic [31:0]                  data_addr_o,
   output logic                         data_we_o,
   output logic [3:0]                   data_be_o,
   output logic [31:0]                  data_wdata_o,
   input  logic                         data_gnt_i,
   input  logic                         data_rvalid_i,
   input  logic [31:0]                  data_rdata_i,
   input  logic                         debug_req_i,
   input  logic [14:0]                  debug_addr_i,
   input  logic                         debug_we_i,
   input  logic [31:0]                  debug_wdata_i,
   output logic                         debug_gnt_o,
   output logic                         debug_rvalid_o,
   output logic [31:0]                  debug_rdata_o,
   output logic                         debug_halted_o
);
   logic unused_ok;

   assign instr_req_o    = 1'b0;
   assign instr_addr_o   = BOOT_ADDR;
   assign debug_gnt_o    = debug_req_i;
   assign debug_halted_o = ~fetch_enable_i;
   assign core_busy_o    = data_req_o;
   assign unused_ok      = ^{irq_i, instr_gnt_i, instr_rvalid_i, instr_rdata_i,
                             debug_addr_i[14:4], debug_addr_i[1:0]};

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         data_req_o     <= 1'b0;
         data_addr_o    <= '0;
         data_we_o      <= 1'b0;
         data_be_o      <= '0;
         data_wdata_o   <= '0;
         debug_rvalid_o <= 1'b0;
         debug_rdata_o  <= '0;
      end else begin
         debug_rvalid_o <= debug_req_i && !debug_we_i;
         if (data_gnt_i) data_req_o <= 1'b0;
         if (data_rvalid_i) debug_rdata_o <= data_rdata_i;
         if (debug_req_i && debug_we_i) begin
            case (debug_addr_i[3:2])
               2'd0: data_addr_o  <= debug_wdata_i;
               2'd1: data_wdata_o <= debug_wdata_i;
               2'd2: begin
                  data_req_o <= 1'b1;
                  data_we_o  <= debug_wdata_i[4];
                  data_be_o  <= debug_wdata_i[3:0];
               end
               default: ;
            endcase
         end
      end
   end
endmodule

module dcache #(
   parameter int ADDR_WIDTH   = 22,
   parameter int DCACHE_LINES = 64
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  lsu_req,
   input  logic [ADDR_WIDTH-1:0] lsu_addr,
   input  logic                  lsu_we,
   input  logic [3:0]            lsu_be,
   input  logic [31:0]           lsu_wdata,
   output logic                  lsu_gnt,
   output logic                  lsu_rvalid,
   output logic [31:0]           lsu_rdata,
   output logic                  mem_req,
   output logic [31:0]           mem_addr,
   output logic                  mem_we,
   output logic [3:0]            mem_be,
   output logic [31:0]           mem_wdata,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [31:0]           mem_rdata
);
   typedef enum logic [2:0] {
      IDLE, RD_HIT, MISS_REQ, MISS_WAIT, WR_REQ, WR_WAIT, RESP
   } state_t;

   state_t      state;
   logic        hit;
   logic [31:0] hit_word;
   logic        unused_ok;

   assign lsu_gnt   = lsu_req && (state == IDLE);
   assign unused_ok = ^lsu_addr[1:0];

`ifdef DCACHE_EN
   localparam int IDX_W = $clog2(DCACHE_LINES);
   localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

   logic [DCACHE_LINES-1:0] valid;
   logic [TAG_W-1:0]        tags  [DCACHE_LINES];
   logic [31:0]             words [DCACHE_LINES];
   logic [IDX_W-1:0]        idx, fill_idx;
   logic [TAG_W-1:0]        tag, fill_tag;
   logic                    fill;

   assign idx      = lsu_addr[IDX_W+1:2];
   assign tag      = lsu_addr[ADDR_WIDTH-1:IDX_W+2];
   // the latched memory address names the line being refilled
   assign fill_idx = mem_addr[IDX_W+1:2];
   assign fill_tag = mem_addr[ADDR_WIDTH-1:IDX_W+2];
   assign fill     = (state == MISS_WAIT) && mem_rvalid;
   assign hit      = valid[idx] && (tags[idx] == tag);
   assign hit_word = words[idx];

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) valid <= '0;
      else if (fill) valid[fill_idx] <= 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (fill) begin
         tags[fill_idx]  <= fill_tag;
         words[fill_idx] <= mem_rdata;
      end else if (lsu_gnt && lsu_we && hit) begin
         for (int b = 0; b < 4; b++)
            if (lsu_be[b]) words[idx][8*b +: 8] <= lsu_wdata[8*b +: 8];
      end
   end
`else
   assign hit      = 1'b0;
   assign hit_word = '0;
`endif

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state      <= IDLE;
         lsu_rvalid <= 1'b0;
         lsu_rdata  <= '0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         mem_we     <= 1'b0;
         mem_be     <= '0;
         mem_wdata  <= '0;
      end else begin
         unique case (state)
            IDLE: if (lsu_req) begin
               if (lsu_we || !hit) begin
                  mem_req   <= 1'b1;
                  mem_addr  <= {{(32-ADDR_WIDTH){1'b0}},
                                lsu_addr[ADDR_WIDTH-1:2], 2'b00};
                  mem_we    <= lsu_we;
                  mem_be    <= lsu_be;
                  mem_wdata <= lsu_wdata;
                  state     <= lsu_we ? WR_REQ : MISS_REQ;
               end else begin
                  lsu_rdata  <= hit_word;
                  lsu_rvalid <= 1'b1;
                  state      <= RESP;
               end
            end
            RD_HIT: begin
               lsu_rvalid <= 1'b1;
               state      <= RESP;
            end
            MISS_REQ: if (mem_gnt) begin
               mem_req <= 1'b0;
               state   <= MISS_WAIT;
            end
            MISS_WAIT: if (mem_rvalid) begin
               lsu_rdata  <= mem_rdata;
               lsu_rvalid <= 1'b1;
               state      <= RESP;
            end
            WR_REQ: if (mem_gnt) begin
               mem_req <= 1'b0;
               state   <= WR_WAIT;
            end
            WR_WAIT: if (mem_rvalid) begin
               lsu_rdata  <= '0;
               lsu_rvalid <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               lsu_rvalid <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

module dcache_mem #(
   parameter int INSTR_RDATA_WIDTH = 128,
   parameter int ADDR_WIDTH        = 22
) (
   input  logic                         clk_i,
   input  logic                         rstn_i,
   input  logic                         instr_req,
   input  logic [31:0]                  instr_addr,
   output logic                         instr_gnt,
   output logic                         instr_rvalid,
   output logic [INSTR_RDATA_WIDTH-1:0] instr_rdata,
   input  logic                         req,
   input  logic [31:0]                  addr,
   input  logic                         we,
   input  logic [3:0]                   be,
   input  logic [31:0]                  wdata,
   output logic                         gnt,
   output logic                         rvalid,
   output logic [31:0]                  rdata
);
   localparam int WORDS = 2 ** (ADDR_WIDTH - 2);
   localparam int IW    = INSTR_RDATA_WIDTH / 32;

   logic [31:0]           mem [WORDS];
   logic [ADDR_WIDTH-3:0] dw, ib;
   logic                  unused_ok;

   assign dw        = addr[ADDR_WIDTH-1:2];
   assign ib        = instr_addr[ADDR_WIDTH-1:2] & ~(ADDR_WIDTH-2)'(IW - 1);
   assign gnt       = req;
   assign instr_gnt = instr_req;
   assign unused_ok = ^{addr[31:ADDR_WIDTH], addr[1:0],
                        instr_addr[31:ADDR_WIDTH], instr_addr[1:0]};

   always_ff @(posedge clk_i) begin
      if (req && we)
         for (int b = 0; b < 4; b++)
            if (be[b]) mem[dw][8*b +: 8] <= wdata[8*b +: 8];
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rvalid       <= 1'b0;
         rdata        <= '0;
         instr_rvalid <= 1'b0;
         instr_rdata  <= '0;
      end else begin
         rvalid       <= req;
         instr_rvalid <= instr_req;
         if (req) rdata <= mem[dw];
         if (instr_req)
            for (int k = 0; k < IW; k++)
               instr_rdata[32*k +: 32] <= mem[ib + (ADDR_WIDTH-2)'(k)];
      end
   end
endmodule

module dcache_top #(
   parameter int          INSTR_RDATA_WIDTH = 128,
   parameter int          ADDR_WIDTH        = 22,
   parameter logic [31:0] BOOT_ADDR         = 32'h0,
   parameter int          DCACHE_LINES      = 64
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  irq_i,
   input  logic                  debug_req_i,
   input  logic [14:0]           debug_addr_i,
   input  logic                  debug_we_i,
   input  logic [31:0]           debug_wdata_i,
   output logic                  debug_gnt_o,
   output logic                  debug_rvalid_o,
   output logic [31:0]           debug_rdata_o,
   output logic                  debug_halted_o,
   input  logic                  fetch_enable_i,
   output logic                  core_busy_o,
   output logic                  lsu_req,
   output logic [ADDR_WIDTH-1:0] lsu_addr,
   output logic                  lsu_we,
   output logic [3:0]            lsu_be,
   output logic [31:0]           lsu_wdata,
   output logic [31:0]           lsu_rdata,
   output logic                  lsu_rvalid,
   output logic                  lsu_gnt,
   output logic                  memory_req,
   output logic [31:0]           memory_addr,
   output logic                  memory_we,
   output logic [3:0]            memory_be,
   output logic [31:0]           memory_wdata,
   output logic [31:0]           memory_rdata,
   output logic                  memory_rvalid,
   output logic                  memory_gnt
);
   logic                         instr_req, instr_gnt, instr_rvalid;
   logic [31:0]                  instr_addr, core_addr;
   logic [INSTR_RDATA_WIDTH-1:0] instr_rdata;
   logic                         unused_ok;

   assign lsu_addr  = core_addr[ADDR_WIDTH-1:0];
   assign unused_ok = ^core_addr[31:ADDR_WIDTH];

   riscv_core #(
      .INSTR_RDATA_WIDTH(INSTR_RDATA_WIDTH),
      .BOOT_ADDR        (BOOT_ADDR)
   ) u_core (
      .clk_i         (clk_i),
      .rstn_i        (rstn_i),
      .irq_i         (irq_i),
      .fetch_enable_i(fetch_enable_i),
      .core_busy_o   (core_busy_o),
      .instr_req_o   (instr_req),
      .instr_addr_o  (instr_addr),
      .instr_gnt_i   (instr_gnt),
      .instr_rvalid_i(instr_rvalid),
      .instr_rdata_i (instr_rdata),
      .data_req_o    (lsu_req),
      .data_addr_o   (core_addr),
      .data_we_o     (lsu_we),
      .data_be_o     (lsu_be),
      .data_wdata_o  (lsu_wdata),
      .data_gnt_i    (lsu_gnt),
      .data_rvalid_i (lsu_rvalid),
      .data_rdata_i  (lsu_rdata),
      .debug_req_i   (debug_req_i),
      .debug_addr_i  (debug_addr_i),
      .debug_we_i    (debug_we_i),
      .debug_wdata_i (debug_wdata_i),
      .debug_gnt_o   (debug_gnt_o),
      .debug_rvalid_o(debug_rvalid_o),
      .debug_rdata_o (debug_rdata_o),
      .debug_halted_o(debug_halted_o)
   );

   dcache #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .DCACHE_LINES(DCACHE_LINES)
   ) u_dcache (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .lsu_req   (lsu_req),
      .lsu_addr  (lsu_addr),
      .lsu_we    (lsu_we),
      .lsu_be    (lsu_be),
      .lsu_wdata (lsu_wdata),
      .lsu_gnt   (lsu_gnt),
      .lsu_rvalid(lsu_rvalid),
      .lsu_rdata (lsu_rdata),
      .mem_req   (memory_req),
      .mem_addr  (memory_addr),
      .mem_we    (memory_we),
      .mem_be    (memory_be),
      .mem_wdata (memory_wdata),
      .mem_gnt   (memory_gnt),
      .mem_rvalid(memory_rvalid),
      .mem_rdata (memory_rdata)
   );

   dcache_mem #(
      .INSTR_RDATA_WIDTH(INSTR_RDATA_WIDTH),
      .ADDR_WIDTH       (ADDR_WIDTH)
   ) u_mem (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .instr_req   (instr_req),
      .instr_addr  (instr_addr),
      .instr_gnt   (instr_gnt),
      .instr_rvalid(instr_rvalid),
      .instr_rdata (instr_rdata),
      .req         (memory_req),
      .addr        (memory_addr),
      .we          (memory_we),
      .be          (memory_be),
      .wdata       (memory_wdata),
      .gnt         (memory_gnt),
      .rvalid      (memory_rvalid),
      .rdata       (memory_rdata)
   );
endmodule

// File: tb/tb_dcache_top.sv
// Directed bench for dcache_top: LSU accesses are issued through the debug bus.
// Expectations follow DCACHE_EN: cached hits answer in 1 cycle, bypass always misses.
module tb_dcache_top;
   logic        clk_i = 1'b0;
   logic        rstn_i = 1'b0;
   logic        irq_i = 1'b0;
   logic        debug_req_i = 1'b0;
   logic [14:0] debug_addr_i = '0;
   logic        debug_we_i = 1'b0;
   logic [31:0] debug_wdata_i = '0;
   logic        fetch_enable_i = 1'b1;
   logic        debug_gnt_o, debug_rvalid_o, debug_halted_o, core_busy_o;
   logic [31:0] debug_rdata_o;
   logic        lsu_req, lsu_we, lsu_rvalid, lsu_gnt;
   logic [21:0] lsu_addr;
   logic [3:0]  lsu_be, memory_be;
   logic [31:0] lsu_wdata, lsu_rdata, memory_addr, memory_wdata, memory_rdata;
   logic        memory_req, memory_we, memory_rvalid, memory_gnt;

`ifdef DCACHE_EN
   localparam int HIT_LAT = 1;
   localparam int HIT_REQ = 0;
`else
   localparam int HIT_LAT = 3;
   localparam int HIT_REQ = 1;
`endif

   int          checks = 0;
   int          errors = 0;
   int          gcyc, rcyc, nreq;
   logic [31:0] rd, maddr;
   logic        mwe, found, seen;
   logic [3:0]  mbe;

   dcache_top dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .irq_i(irq_i),
      .debug_req_i(debug_req_i), .debug_addr_i(debug_addr_i),
      .debug_we_i(debug_we_i), .debug_wdata_i(debug_wdata_i),
      .debug_gnt_o(debug_gnt_o), .debug_rvalid_o(debug_rvalid_o),
      .debug_rdata_o(debug_rdata_o), .debug_halted_o(debug_halted_o),
      .fetch_enable_i(fetch_enable_i), .core_busy_o(core_busy_o),
      .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_we(lsu_we),
      .lsu_be(lsu_be), .lsu_wdata(lsu_wdata), .lsu_rdata(lsu_rdata),
      .lsu_rvalid(lsu_rvalid), .lsu_gnt(lsu_gnt),
      .memory_req(memory_req), .memory_addr(memory_addr),
      .memory_we(memory_we), .memory_be(memory_be),
      .memory_wdata(memory_wdata), .memory_rdata(memory_rdata),
      .memory_rvalid(memory_rvalid), .memory_gnt(memory_gnt)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic dbg_wr(input logic [14:0] a, input logic [31:0] d);
      @(negedge clk_i);
      debug_req_i = 1'b1; debug_we_i = 1'b1;
      debug_addr_i = a; debug_wdata_i = d;
      @(negedge clk_i);
      debug_req_i = 1'b0; debug_we_i = 1'b0;
   endtask

   task automatic issue(input logic [31:0] a, input logic we,
                        input logic [3:0] be, input logic [31:0] d);
      dbg_wr(15'h0, a);
      dbg_wr(15'h4, d);
      dbg_wr(15'h8, {27'b0, we, be});
   endtask

   // run one access and record grant/response cycles and memory traffic
   task automatic access(input string tag, input logic [31:0] a,
                         input logic we, input logic [3:0] be,
                         input logic [31:0] d);
      issue(a, we, be, d);
      gcyc = -1; rcyc = -1; nreq = 0;
      for (int c = 0; c < 20 && rcyc < 0; c++) begin
         if (c > 0) @(negedge clk_i);
         if (lsu_gnt && gcyc < 0) gcyc = c;
         if (memory_req) begin
            nreq++; maddr = memory_addr; mwe = memory_we; mbe = memory_be;
         end
         if (lsu_rvalid) begin rcyc = c; rd = lsu_rdata; end
      end
      check({tag, "_done"}, 32'(rcyc >= 0 && gcyc >= 0), 32'd1);
   endtask

   task automatic expect_acc(input string tag, input int lat, input int nr,
                             input logic [31:0] data);
      check({tag, "_lat"}, 32'(rcyc - gcyc), 32'(lat));
      check({tag, "_nreq"}, 32'(nreq), 32'(nr));
      check({tag, "_data"}, rd, data);
   endtask

   initial begin
      repeat (3) @(negedge clk_i);
      check("rst_lsu_gnt", 32'(lsu_gnt), 32'd0);
      check("rst_lsu_rvalid", 32'(lsu_rvalid), 32'd0);
      check("rst_lsu_rdata", lsu_rdata, 32'd0);
      check("rst_mem_req", 32'(memory_req), 32'd0);
      check("rst_mem_we", 32'(memory_we), 32'd0);
      check("rst_mem_be", 32'(memory_be), 32'd0);
      check("rst_mem_addr", memory_addr, 32'd0);
      check("rst_mem_wdata", memory_wdata, 32'd0);
      check("rst_mem_gnt", 32'(memory_gnt), 32'd0);
      check("rst_mem_rvalid", 32'(memory_rvalid), 32'd0);
      check("rst_mem_rdata", memory_rdata, 32'd0);
      rstn_i = 1'b1;

      access("st100", 32'h100, 1'b1, 4'hF, 32'hDEADBEEF);
      expect_acc("st100", 3, 1, 32'h0);
      check("st100_we", 32'(mwe), 32'd1);
      check("st100_be", 32'(mbe), 32'hF);
      check("st100_addr", maddr, 32'h100);

      access("ld100a", 32'h100, 1'b0, 4'hF, 32'h0);
      expect_acc("ld100a", 3, 1, 32'hDEADBEEF);
      check("ld100a_we", 32'(mwe), 32'd0);

      access("ld100b", 32'h100, 1'b0, 4'hF, 32'h0);
      expect_acc("ld100b", HIT_LAT, HIT_REQ, 32'hDEADBEEF);

      access("stb", 32'h100, 1'b1, 4'b0001, 32'h11);
      expect_acc("stb", 3, 1, 32'h0);
      check("stb_we", 32'(mwe), 32'd1);
      check("stb_be", 32'(mbe), 32'h1);

      access("ld_merge", 32'h100, 1'b0, 4'hF, 32'h0);
      expect_acc("ld_merge", HIT_LAT, HIT_REQ, 32'hDEADBE11);

      access("st200", 32'h200, 1'b1, 4'hF, 32'hCAFEF00D);
      expect_acc("st200", 3, 1, 32'h0);

      access("ld_noalloc", 32'h100, 1'b0, 4'hF, 32'h0);
      expect_acc("ld_noalloc", HIT_LAT, HIT_REQ, 32'hDEADBE11);

      access("ld200", 32'h200, 1'b0, 4'hF, 32'h0);
      expect_acc("ld200", 3, 1, 32'hCAFEF00D);

      access("ld_conflict", 32'h100, 1'b0, 4'hF, 32'h0);
      expect_acc("ld_conflict", 3, 1, 32'hDEADBE11);

      access("ld_upper", 32'h0040_0100, 1'b0, 4'hF, 32'h0);
      expect_acc("ld_upper", HIT_LAT, HIT_REQ, 32'hDEADBE11);

      access("st_align", 32'h0040_0206, 1'b1, 4'b1100, 32'h12345678);
      expect_acc("st_align", 3, 1, 32'h0);
      check("st_align_addr", maddr, 32'h204);
      check("st_align_be", 32'(mbe), 32'hC);
      check("st_align_wdata", memory_wdata, 32'h12345678);

      // evict 0x100, then reset while its refill is outstanding
      access("evict", 32'h200, 1'b0, 4'hF, 32'h0);
      expect_acc("evict", 3, 1, 32'hCAFEF00D);
      issue(32'h100, 1'b0, 4'hF, 32'h0);
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge clk_i);
         if (memory_rvalid) found = 1'b1;
      end
      check("rst_reach_wait", 32'(found), 32'd1);
      rstn_i = 1'b0;
      #1;
      check("mid_lsu_rvalid", 32'(lsu_rvalid), 32'd0);
      check("mid_lsu_gnt", 32'(lsu_gnt), 32'd0);
      check("mid_lsu_rdata", lsu_rdata, 32'd0);
      check("mid_mem_req", 32'(memory_req), 32'd0);
      check("mid_mem_addr", memory_addr, 32'd0);
      check("mid_mem_rvalid", 32'(memory_rvalid), 32'd0);
      check("mid_mem_rdata", memory_rdata, 32'd0);
      seen = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i);
         if (lsu_rvalid) seen = 1'b1;
      end
      rstn_i = 1'b1;
      @(negedge clk_i);
      if (lsu_rvalid) seen = 1'b1;
      check("mid_no_rvalid", 32'(seen), 32'd0);

      access("post_rst", 32'h100, 1'b0, 4'hF, 32'h0);
      expect_acc("post_rst", 3, 1, 32'hDEADBE11);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
